// File: rtl/ftq_queue.sv
// ftq_queue: parametrised fetch target queue between the BPU and the IFU.
// The BPU enqueues fetch blocks in order, the IFU takes them in order, and the
// backend retires them on commit. A redirect drops every entry younger than
// the mispredicted one.
// Optional build macro: FTQ_PERF_COUNTER_EN enables the two saturating
// performance counters. When it is not defined, both ports read 0.
module ftq_queue #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned COMMIT_WIDTH  = 2,
    localparam int unsigned IDW          = $clog2(DEPTH),
    localparam int unsigned CNW          = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bpu_valid,
    input  logic [PAYLOAD_WIDTH-1:0] bpu_payload,
    output logic                     bpu_ready,
    output logic [IDW-1:0]           bpu_id,
    output logic                     ifu_valid,
    output logic [PAYLOAD_WIDTH-1:0] ifu_payload,
    output logic [IDW-1:0]           ifu_id,
    input  logic                     ifu_ready,
    input  logic [CNW-1:0]           commit_num,
    input  logic                     redirect_valid,
    input  logic [IDW-1:0]           redirect_id,
    output logic [IDW:0]             count,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_redirects
);

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    logic [IDW:0]             bpu_ptr_q, bpu_ptr_d;
    logic [IDW:0]             ifu_ptr_q, ifu_ptr_d;
    logic [IDW:0]             comm_ptr_q, comm_ptr_d;
    logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];

    logic                     full;
    logic                     enq_fire;
    logic                     iss_fire;
    logic [IDW-1:0]           redir_off;
    logic [IDW:0]             redir_ptr;

    assign count       = bpu_ptr_q - comm_ptr_q;
    assign full        = (count == (IDW + 1)'(DEPTH));
    assign bpu_ready   = !full && !redirect_valid;
    assign ifu_valid   = (ifu_ptr_q != bpu_ptr_q) && !redirect_valid;
    assign bpu_id      = bpu_ptr_q[IDW-1:0];
    assign ifu_id      = ifu_ptr_q[IDW-1:0];
    assign ifu_payload = mem_q[ifu_ptr_q[IDW-1:0]];

    assign enq_fire    = bpu_valid && bpu_ready;
    assign iss_fire    = ifu_valid && ifu_ready;

    // The redirect target is found as a distance from the oldest live entry.
    // That distance is then added to the full-width comm_ptr so that the
    // wrap bit stays consistent.
    assign redir_off   = redirect_id - comm_ptr_q[IDW-1:0];
    assign redir_ptr   = comm_ptr_q + {1'b0, redir_off} + (IDW + 1)'(1);

    // Next-state pointer arithmetic. A redirect overrides enqueue and issue,
    // but commit still applies in the same cycle.
    always_comb begin
        bpu_ptr_d  = bpu_ptr_q;
        ifu_ptr_d  = ifu_ptr_q;
        comm_ptr_d = comm_ptr_q + (IDW + 1)'(commit_num);
        if (redirect_valid) begin
            bpu_ptr_d = redir_ptr;
            ifu_ptr_d = redir_ptr;
        end else begin
            if (enq_fire) begin
                bpu_ptr_d = bpu_ptr_q + (IDW + 1)'(1);
            end
            if (iss_fire) begin
                ifu_ptr_d = ifu_ptr_q + (IDW + 1)'(1);
            end
        end
    end

    // Pointer registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bpu_ptr_q  <= '0;
            ifu_ptr_q  <= '0;
            comm_ptr_q <= '0;
        end else begin
            bpu_ptr_q  <= bpu_ptr_d;
            ifu_ptr_q  <= ifu_ptr_d;
            comm_ptr_q <= comm_ptr_d;
        end
    end

    // Payload storage. It is not reset, and it is written only on an accepted enqueue.
    always_ff @(posedge clk) begin
        if (enq_fire && !rst) begin
            mem_q[bpu_ptr_q[IDW-1:0]] <= bpu_payload;
        end
    end

`ifdef FTQ_PERF_COUNTER_EN
    logic [31:0] perf_full_q, perf_full_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    // Saturating event counters.
    always_comb begin
        perf_full_d  = perf_full_q;
        perf_redir_d = perf_redir_q;
        if (bpu_valid && full && (perf_full_q != '1)) begin
            perf_full_d = perf_full_q + 32'd1;
        end
        if (redirect_valid && (perf_redir_q != '1)) begin
            perf_redir_d = perf_redir_q + 32'd1;
        end
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_full_q  <= perf_full_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_full_cycles = perf_full_q;
    assign perf_redirects   = perf_redir_q;
`else
    assign perf_full_cycles = '0;
    assign perf_redirects   = '0;
`endif

`ifndef SYNTHESIS
    // Protocol checks on the backend interface.
    a_commit_width : assert property (@(posedge clk) disable iff (rst)
        commit_num <= CNW'(COMMIT_WIDTH));
    a_commit_issued : assert property (@(posedge clk) disable iff (rst)
        (IDW + 1)'(commit_num) <= (ifu_ptr_q - comm_ptr_q));
    a_redirect_range : assert property (@(posedge clk) disable iff (rst)
        redirect_valid |-> ({1'b0, redir_off} < (ifu_ptr_q - comm_ptr_q)));
`endif

endmodule

// File: doc/ftq_queue.md
Name: ftq_queue

Overview:
- Parametrised fetch target queue between the BPU and the IFU.
- Holds BPU-predicted fetch blocks (opaque payload) in order, issues them to the IFU, and retires them on backend commit.
- A backend redirect discards all entries younger than the mispredicted one.
- Generalises the fixed 8-entry frontend FTQ: the depth, payload width and commit width are now parameters.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2 (frontend FTQ size)
- PAYLOAD_WIDTH, 64, bits per entry (e.g. start PC + length + prediction meta)
- COMMIT_WIDTH, 2, maximum entries retired per cycle
- IDW, $clog2(DEPTH), entry index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- bpu_valid  in  1  BPU offers an entry
- bpu_payload  in  PAYLOAD_WIDTH  entry contents
- bpu_ready  out  1  queue can accept
- bpu_id  out  IDW  index the offered entry will occupy
- ifu_valid  out  1  unissued entry available
- ifu_payload  out  PAYLOAD_WIDTH  contents of oldest unissued entry
- ifu_id  out  IDW  index of that entry
- ifu_ready  in  1  IFU accepts
- commit_num  in  $clog2(COMMIT_WIDTH+1)  entries retired this cycle
- redirect_valid  in  1  backend mispredict
- redirect_id  in  IDW  index of mispredicted entry (kept; younger ones dropped)
- count  out  $clog2(DEPTH)+1  occupied entries
- perf_full_cycles  out  32  see optional feature
- perf_redirects  out  32  see optional feature

Behaviour:
- Reset (synchronous, active-high): clk and rst only; polarity and synchronicity fixed.
  - Pointers bpu_ptr, ifu_ptr and comm_ptr are IDW+1 bits (extra wrap bit); all three reset to 0.
  - Reset outputs: bpu_ready=1, ifu_valid=0, count=0, bpu_id=0, ifu_id=0, perf counters=0.
  - Payload storage is not reset.
  - rst overrides every other input in the same cycle.
- Ordering invariant: comm_ptr ≤ ifu_ptr ≤ bpu_ptr, modulo 2·DEPTH.
- Full and empty:
  - count = bpu_ptr − comm_ptr.
  - Full when count==DEPTH; bpu_ready = !full && !redirect_valid.
  - ifu_valid = (ifu_ptr != bpu_ptr) && !redirect_valid.
- Enqueue: on bpu_valid && bpu_ready, write mem[bpu_ptr[IDW-1:0]] and increment bpu_ptr.
  - The entry is visible on ifu_* the next cycle; no bypass.
- Issue:
  - ifu_payload = mem[ifu_ptr[IDW-1:0]], combinational read.
  - On ifu_valid && ifu_ready, ifu_ptr increments.
- Commit:
  - comm_ptr += commit_num each cycle.
  - commit_num must be ≤ COMMIT_WIDTH and ≤ ifu_ptr − comm_ptr; entries are only committed after issue.
  - A violation fires a simulation assertion; RTL behaviour in that case is undefined.
  - A full queue frees entries the cycle after commit; a commit does not allow an enqueue in the same cycle.
- Redirect:
  - Compute off = (redirect_id − comm_ptr[IDW-1:0]) mod DEPTH.
  - bpu_ptr and ifu_ptr both become comm_ptr + off + 1, using the wrap-bit arithmetic on full IDW+1-bit pointers.
  - Enqueue and issue handshakes are suppressed in the redirect cycle; valid/ready are forced low.
  - commit_num still applies in the same cycle.
  - redirect_id must lie in [comm_ptr, ifu_ptr); otherwise an assertion fires.
  - Redirect while full: the queue becomes non-full next cycle if any entries are dropped.
- Wrap-around: pointers wrap at 2·DEPTH; indices wrap at DEPTH. There are no bubbles at the wrap.

Optional Feature:
- Macro: FTQ_PERF_COUNTER_EN.
- Defined:
  - perf_full_cycles increments each cycle with bpu_valid && full.
  - perf_redirects increments on each redirect_valid.
  - Both are 32-bit saturating counters cleared by rst.
- Undefined: both ports are tied to constant 0 and no counter flops are generated.

Test Plan:
- DEPTH=8, reset:
  - Stimulus: enqueue payloads 0x10..0x17 back-to-back, ifu_ready=0.
  - Required: bpu_ready falls after the 8th accept; count=8; ifu_valid=1 with ifu_payload=0x10 and ifu_id=0.
- Full, issue 8, commit:
  - Stimulus: issue all 8 with ifu_ready=1, then commit_num=2 for one cycle.
  - Required: count 8→6; bpu_ready=1 the next cycle; the next enqueue gets bpu_id=0 (wrap).
- Redirect:
  - Stimulus: 6 entries, 5 issued, comm_ptr=0; redirect_id=2.
  - Required: next cycle count=3, ifu_valid=0, bpu_id=3; the redirect-cycle bpu_valid is not written.
- Redirect with commit:
  - Stimulus: comm_ptr=6 (wrapped region); redirect_id=1 with commit_num=1 in the same cycle.
  - Required: comm_ptr=7, bpu_ptr=ifu_ptr=comm_ptr_old+3+1=10 (index 2).
- Simultaneous ops:
  - Stimulus: enqueue + issue + commit_num=1 in one cycle at count=4.
  - Required: count stays 4; ifu_id advances by 1.
- FTQ_PERF_COUNTER_EN defined:
  - Stimulus: 5 cycles of bpu_valid while full, then 2 redirects.
  - Required: perf_full_cycles=5, perf_redirects=2.
  - Undefined: both read 0.
